// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: snoops the CPU fetch PC and data-store bus to decide when a
// program run ends (to-host pass/fail, PC halt loop or cycle timeout) and
// buffers words the program writes to the result mailbox in a small FIFO.
module cpu_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FF0,
  parameter logic [31:0] RESULT_ADDR    = 32'h0000_0FF4,
  parameter int          RESULT_DEPTH   = 8,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          HALT_CYCLES    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   pc,
  input  logic [31:0]                   memory_address,
  input  logic [31:0]                   memory_write,
  input  logic [3:0]                    memory_byte_enable,
  input  logic                          memory_we,
  input  logic                          result_ready,
  output logic                          result_valid,
  output logic [31:0]                   result_data,
  output logic [$clog2(RESULT_DEPTH):0] result_count,
  output logic                          overflow,
  output logic                          done,
  output logic [2:0]                    status,
  output logic [30:0]                   fail_code,
  output logic [31:0]                   cycle_count
);

  localparam int PW = $clog2(RESULT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_LIM   = CW'(RESULT_DEPTH);
  localparam logic [31:0]   HALT_LIM    = 32'(HALT_CYCLES);
  localparam logic [31:0]   TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  localparam logic [2:0] STATUS_RUN     = 3'd0;
  localparam logic [2:0] STATUS_PASS    = 3'd1;
  localparam logic [2:0] STATUS_FAIL    = 3'd2;
  localparam logic [2:0] STATUS_HALT    = 3'd3;
  localparam logic [2:0] STATUS_TIMEOUT = 3'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [2:0]    status_r, status_s;
  logic [30:0]   fail_code_r, fail_code_s;
  logic [31:0]   cycle_count_r, cycle_count_s;
  logic          done_r;

  logic [31:0]   pc_q_r;
  logic          pc_seen_r;
  logic [31:0]   stall_cnt_r;

  logic          store_qual_s;
  logic          tohost_hit_s;
  logic          stall_match_s;
  logic          halt_hit_s;
  logic          timeout_hit_s;

  logic [31:0]   fifo_mem_r [RESULT_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_s;
  logic          valid_r;
  logic          overflow_r;
  logic          push_req_s, push_s, pop_s, drop_s, full_s;

  // Decode the store bus and the run-ending events for this cycle.
  always_comb begin
    store_qual_s  = memory_we && (memory_byte_enable == 4'hF);
    tohost_hit_s  = 1'b0;
    stall_match_s = pc_seen_r && (pc == pc_q_r);
    halt_hit_s    = 1'b0;
    timeout_hit_s = 1'b0;
    if (store_qual_s && (memory_address == TOHOST_ADDR) && (memory_write != 32'd0)) begin
      tohost_hit_s = 1'b1;
    end else begin
      tohost_hit_s = 1'b0;
    end
    // Halt fires on the edge where the stall count would reach the limit.
    if ((HALT_LIM != 32'd0) && stall_match_s && ((stall_cnt_r + 32'd1) == HALT_LIM)) begin
      halt_hit_s = 1'b1;
    end else begin
      halt_hit_s = 1'b0;
    end
    if ((TIMEOUT_LIM != 32'd0) && ((cycle_count_r + 32'd1) == TIMEOUT_LIM)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Run/done next-state logic; to-host outranks halt, halt outranks timeout.
  always_comb begin
    state_s       = state_r;
    status_s      = status_r;
    fail_code_s   = fail_code_r;
    cycle_count_s = cycle_count_r;
    case (state_r)
      ST_RUN: begin
        cycle_count_s = cycle_count_r + 32'd1;
        if (tohost_hit_s) begin
          state_s = ST_DONE;
          if (memory_write == 32'd1) begin
            status_s = STATUS_PASS;
          end else begin
            status_s    = STATUS_FAIL;
            fail_code_s = memory_write[31:1];
          end
        end else if (halt_hit_s) begin
          state_s  = ST_DONE;
          status_s = STATUS_HALT;
        end else if (timeout_hit_s) begin
          state_s  = ST_DONE;
          status_s = STATUS_TIMEOUT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_DONE;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Run-state, verdict and cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      status_r      <= STATUS_RUN;
      fail_code_r   <= 31'd0;
      cycle_count_r <= 32'd0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      status_r      <= status_s;
      fail_code_r   <= fail_code_s;
      cycle_count_r <= cycle_count_s;
      done_r        <= (state_s == ST_DONE);
    end
  end

  // Track how long the fetch PC has stayed put; the first cycle after reset has no history.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q_r      <= 32'd0;
      pc_seen_r   <= 1'b0;
      stall_cnt_r <= 32'd0;
    end else begin
      pc_q_r    <= pc;
      pc_seen_r <= 1'b1;
      if (stall_match_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= 32'd0;
      end
    end
  end

  // FIFO push/pop arbitration; a push into a full FIFO only survives with a same-edge pop.
  always_comb begin
    full_s     = (count_r == DEPTH_LIM);
    pop_s      = valid_r && result_ready;
    push_req_s = (state_r == ST_RUN) && store_qual_s && (memory_address == RESULT_ADDR);
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    count_s    = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r    <= count_s;
      valid_r    <= (count_s != CW'(0));
      overflow_r <= overflow_r | drop_s;
    end
  end

  // FIFO storage; contents are don't-care until written, reads are gated by valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= memory_write;
    end
  end

  // Head-of-FIFO read, forced to zero while empty so reset shows all-zero outputs.
  always_comb begin
    if (valid_r) begin
      result_data = fifo_mem_r[rd_ptr_r];
    end else begin
      result_data = 32'd0;
    end
  end

  assign result_valid = valid_r;
  assign result_count = count_r;
  assign overflow     = overflow_r;
  assign done         = done_r;
  assign status       = status_r;
  assign fail_code    = fail_code_r;
  assign cycle_count  = cycle_count_r;

endmodule

// File: doc/cpu_test_monitor.md
# cpu_test_monitor

Parametrised simulation harness block that snoops the CPU's instruction-fetch PC and data-memory write bus. It decides when a program run has finished and why: pass or fail code via a to-host write, PC halt loop, or cycle timeout. It also buffers result words the program writes to a result mailbox. It is instantiated alongside `cpu`, `ram` and `file_program_memory` in every CPU program bench. It replaces fixed-delay `$finish` with a deterministic end-of-test condition and checkable results.

## Interface
Parameters:
- `TOHOST_ADDR`, 32'h0000_0FF0, word address of the pass/fail mailbox
- `RESULT_ADDR`, 32'h0000_0FF4, word address of the result mailbox
- `RESULT_DEPTH`, 8, result FIFO entries (power of two, ≥2)
- `TIMEOUT_CYCLES`, 1000, run-cycle limit; 0 disables timeout
- `HALT_CYCLES`, 4, consecutive cycles of unchanged PC that count as a halt; 0 disables halt detection

Ports:
- `clk`  in  1  clock; one clock for everything
- `rst`  in  1  reset, synchronous, active-high
- `pc`  in  32  CPU fetch PC
- `memory_address`  in  32  CPU data address
- `memory_write`  in  32  CPU store data
- `memory_byte_enable`  in  4  store byte enables
- `memory_we`  in  1  store strobe
- `result_ready`  in  1  bench pops the FIFO head
- `result_valid`  out  1  FIFO non-empty
- `result_data`  out  32  FIFO head word
- `result_count`  out  $clog2(RESULT_DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky; a result push was dropped
- `done`  out  1  run finished (sticky until reset)
- `status`  out  3  0 RUN, 1 PASS, 2 FAIL, 3 HALT, 4 TIMEOUT
- `fail_code`  out  31  `memory_write[31:1]` of a failing to-host write
- `cycle_count`  out  32  run cycles elapsed

## Operation
- Two states: RUN and DONE. Reset enters RUN. All outputs are 0 in reset; `status` is RUN.
- Store qualifier: `memory_we && memory_byte_enable == 4'hF`. A partial-byte store to either mailbox is ignored and stored to RAM normally. The monitor never drives the bus.
- To-host store in RUN:
  - Value 1 -> DONE, PASS.
  - Other nonzero value -> DONE, FAIL, with `fail_code = value[31:1]`.
  - Value 0 is ignored.
- Halt detection:
  - `pc_q` and a `pc_seen` flag register PC every cycle.
  - `stall_cnt` increments when `pc_seen && pc == pc_q`, else it clears.
  - When `stall_cnt` reaches HALT_CYCLES -> DONE, HALT.
  - The first cycle after reset never counts as a stall.
- Timeout: `cycle_count` increments every RUN cycle. When it would reach TIMEOUT_CYCLES -> DONE, TIMEOUT.
- Same-cycle priority: to-host > halt > timeout.
- DONE is terminal until `rst`. In DONE:
  - `cycle_count`, `status` and `fail_code` freeze.
  - Result pushes stop.
  - Pops continue.
- Result FIFO:
  - A result store in RUN pushes `memory_write`.
  - If full without a simultaneous pop, the word is dropped and `overflow` sets.
  - Pop = `result_valid && result_ready`. A pop when empty is ignored.
  - Push + pop when full: both occur, count unchanged, no overflow.
  - Push + pop when empty: push only.
  - Pointers wrap modulo RESULT_DEPTH.
- `rst` mid-run clears everything, including the FIFO and sticky flags, on the next edge.

## Timing
- All state updates on posedge `clk`. Outputs are registered except `result_data`, which is a combinational read of the head entry.
- To-host or result store sampled at edge k -> `done`/`status`, or the FIFO push, visible after edge k (1-cycle latency).
- Pop at edge k -> the next head is on `result_data` after edge k.
- `cycle_count` = 1 after the first edge following reset release. TIMEOUT_CYCLES=N gives `done` after edge N.
- PC constant from edge j onward gives HALT after edge j+HALT_CYCLES.
- `rst` sampled high overrides every other event in that cycle.

## Test plan
- Store 32'h1 to 0xFF0 with BE=4'hF at cycle 10 -> `done`=1, `status`=1 after that edge; `cycle_count` frozen at 10.
- Store 32'h0000_000B to 0xFF0 -> `status`=2, `fail_code`=5. A prior store of 0 to 0xFF0, or BE=4'h1, has no effect.
- Push 9 results 1..9 with DEPTH=8 and no pops -> `result_count`=8, `overflow`=1. Pops return 1..8, then `result_valid`=0. Push + pop on the same edge while full -> count stays 8, no overflow.
- Hold `pc`=0x40 from cycle 20, HALT_CYCLES=4 -> HALT after edge 24. PC toggling between two values never halts.
- Run gcd.dat (result 0x0000_0006 to 0xFF4, then 1 to 0xFF0) with TIMEOUT_CYCLES=1000 -> PASS before timeout, FIFO holds 6. The same PC program with no to-host write -> HALT.
- Same-edge to-host pass and timeout -> PASS. `rst` asserted while FIFO holds 3 and DONE -> all outputs 0, RUN, next edge.
